// File: rtl/graphics_type.sv
// Shared geometry types, table depths and sequencer state encoding for the
// triangle fetch/assembly path.
package graphics_type;

    localparam int MAX_TRI  = 24;
    localparam int NUM_VERT = 18;

    typedef logic [7:0] color_t;

    typedef struct packed {
        logic signed [9:0] x;
        logic signed [9:0] y;
        logic signed [9:0] z;
    } vertex_3d_t;

    typedef struct packed {
        logic [4:0] v0;
        logic [4:0] v1;
        logic [4:0] v2;
        color_t     color;
    } triangle_t;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_FETCH_TRI = 3'd1,
        SEQ_FETCH_V0  = 3'd2,
        SEQ_FETCH_V1  = 3'd3,
        SEQ_FETCH_V2  = 3'd4,
        SEQ_EMIT      = 3'd5,
        SEQ_DONE      = 3'd6
    } seq_state_t;

    function automatic logic idx_bad(input logic [4:0] idx, input int depth);
        return int'(idx) >= depth;
    endfunction

endpackage

// File: rtl/triangle_sequencer_if.sv
// Triangle packet stream from the sequencer to the rasteriser front end.
interface triangle_sequencer_if;
    import graphics_type::*;

    // A packet transfers on a rising edge where out_valid && out_ready; once
    // out_valid is high it stays high and the payload stays frozen until then.
    logic       out_valid;
    logic       out_ready;
    vertex_3d_t out_v0;
    vertex_3d_t out_v1;
    vertex_3d_t out_v2;
    color_t     out_color;
    logic       out_last;

    modport master (
        output out_valid, out_v0, out_v1, out_v2, out_color, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_v0, out_v1, out_v2, out_color, out_last,
        output out_ready
    );

endinterface

// File: rtl/triangle_sequencer.sv
// Walks the scene's triangle table once per frame, fetches the three vertices
// of each triangle and hands out one assembled packet per triangle.
module triangle_sequencer #(
    parameter int MAX_TRI  = graphics_type::MAX_TRI,
    parameter int NUM_VERT = graphics_type::NUM_VERT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [1:0]               model_select_in,
    input  logic signed [9:0]        cam_x_in,
    input  logic signed [9:0]        cam_z_in,
    output logic [1:0]               model_select,
    output logic signed [9:0]        cam_x,
    output logic signed [9:0]        cam_z,
    input  logic [4:0]               num_triangles,
    output logic [4:0]               tri_idx,
    input  graphics_type::triangle_t  tri_in,
    output logic [4:0]               vert_idx,
    input  graphics_type::vertex_3d_t vert_in,
    triangle_sequencer_if.master     pkt,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun,
    output logic                     bad_index,
    output graphics_type::seq_state_t state_dbg
);
    import graphics_type::*;

    localparam int CW = $clog2(MAX_TRI + 1);

    localparam logic [2:0] ST_IDLE      = SEQ_IDLE;
    localparam logic [2:0] ST_FETCH_TRI = SEQ_FETCH_TRI;
    localparam logic [2:0] ST_FETCH_V0  = SEQ_FETCH_V0;
    localparam logic [2:0] ST_FETCH_V1  = SEQ_FETCH_V1;
    localparam logic [2:0] ST_FETCH_V2  = SEQ_FETCH_V2;
    localparam logic [2:0] ST_EMIT      = SEQ_EMIT;
    localparam logic [2:0] ST_DONE      = SEQ_DONE;

    logic [2:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] n_q;
    logic [CW-1:0] n_eff;
    triangle_t     tri_q;
    vertex_3d_t    v0_q, v1_q, v2_q;
    color_t        color_q;
    logic          last_q;
    logic          tri_bad;
    logic          last_tri;

    always_comb begin
        n_eff = CW'(num_triangles);
        if (int'(num_triangles) > MAX_TRI) begin
            n_eff = CW'(MAX_TRI);
        end
    end

    assign tri_bad  = idx_bad(tri_q.v0, NUM_VERT) || idx_bad(tri_q.v1, NUM_VERT) ||
                      idx_bad(tri_q.v2, NUM_VERT);
    assign last_tri = (cnt_q == n_q - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            tri_q        <= '0;
            v0_q         <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            color_q      <= '0;
            last_q       <= 1'b0;
            model_select <= '0;
            cam_x        <= '0;
            cam_z        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        model_select <= model_select_in;
                        cam_x        <= cam_x_in;
                        cam_z        <= cam_z_in;
                        cnt_q        <= '0;
                        state_q      <= ST_FETCH_TRI;
                    end
                end
                ST_FETCH_TRI: begin
                    tri_q <= tri_in;
                    // The count is frozen at the first fetch so a scene-table
                    // update mid-frame cannot truncate or extend the pass.
                    if (cnt_q == '0) begin
                        n_q <= n_eff;
                    end
                    if (cnt_q == '0 && n_eff == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_FETCH_V0;
                    end
                end
                ST_FETCH_V0: begin
                    if (tri_bad) begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= last_tri ? ST_DONE : ST_FETCH_TRI;
                    end else begin
                        v0_q    <= vert_in;
                        state_q <= ST_FETCH_V1;
                    end
                end
                ST_FETCH_V1: begin
                    v1_q    <= vert_in;
                    state_q <= ST_FETCH_V2;
                end
                ST_FETCH_V2: begin
                    v2_q    <= vert_in;
                    color_q <= tri_q.color;
                    last_q  <= last_tri;
                    state_q <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (pkt.out_ready) begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= last_q ? ST_DONE : ST_FETCH_TRI;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tri_idx  = '0;
        vert_idx = '0;
        case (state_q)
            ST_FETCH_TRI: tri_idx  = 5'(cnt_q);
            ST_FETCH_V0:  vert_idx = tri_q.v0;
            ST_FETCH_V1:  vert_idx = tri_q.v1;
            ST_FETCH_V2:  vert_idx = tri_q.v2;
            default: begin
                tri_idx  = '0;
                vert_idx = '0;
            end
        endcase
    end

    assign pkt.out_valid = (state_q == ST_EMIT);
    assign pkt.out_v0    = v0_q;
    assign pkt.out_v1    = v1_q;
    assign pkt.out_v2    = v2_q;
    assign pkt.out_color = color_q;
    assign pkt.out_last  = last_q;

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign overrun    = frame_start && (state_q != ST_IDLE);
    assign bad_index  = (state_q == ST_FETCH_V0) && tri_bad;
    assign state_dbg  = seq_state_t'(state_q);

endmodule

// File: tb/tb_triangle_sequencer.sv
// Directed bench for triangle_sequencer: scene tables modelled in the bench,
// packets captured at the falling edge and compared against expected packets.
module tb_triangle_sequencer;
    import graphics_type::*;

    localparam int PW = 99;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic [1:0]        model_select_in = '0;
    logic signed [9:0] cam_x_in = '0;
    logic signed [9:0] cam_z_in = '0;
    logic [1:0]        model_select;
    logic signed [9:0] cam_x, cam_z;
    logic [4:0]        num_triangles, tri_idx, vert_idx;
    triangle_t         tri_in;
    vertex_3d_t        vert_in;
    logic              busy, frame_done, overrun, bad_index;
    seq_state_t        state_dbg;
    logic [4:0]        scene_n = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    triangle_sequencer_if pkt_if ();

    triangle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .model_select_in(model_select_in), .cam_x_in(cam_x_in), .cam_z_in(cam_z_in),
        .model_select(model_select), .cam_x(cam_x), .cam_z(cam_z),
        .num_triangles(num_triangles), .tri_idx(tri_idx), .tri_in(tri_in),
        .vert_idx(vert_idx), .vert_in(vert_in), .pkt(pkt_if),
        .busy(busy), .frame_done(frame_done), .overrun(overrun),
        .bad_index(bad_index), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // scene model
    function automatic triangle_t mk(input int a, input int b, input int c, input int col);
        triangle_t t;
        t.v0 = 5'(a); t.v1 = 5'(b); t.v2 = 5'(c); t.color = 8'(col);
        return t;
    endfunction

    function automatic triangle_t tri_of(input logic [1:0] m, input logic [4:0] i);
        triangle_t t;
        int k;
        k = int'(i);
        t = '0;
        case (m)
            2'd0: case (i)
                5'd0:  t = mk(0, 1, 2, 'h10);
                5'd1:  t = mk(0, 2, 3, 'h11);
                5'd2:  t = mk(4, 6, 5, 'h12);
                5'd3:  t = mk(4, 7, 6, 'h13);
                5'd4:  t = mk(0, 4, 5, 'h14);
                5'd5:  t = mk(0, 5, 1, 'h15);
                5'd6:  t = mk(1, 5, 6, 'h16);
                5'd7:  t = mk(1, 6, 2, 'h17);
                5'd8:  t = mk(2, 6, 7, 'h18);
                5'd9:  t = mk(2, 7, 3, 'h19);
                5'd10: t = mk(3, 7, 4, 'h1a);
                5'd11: t = mk(3, 4, 0, 'h1b);
                default: t = '0;
            endcase
            2'd1: case (i)
                5'd0: t = mk(0, 1, 2, 'h40);
                5'd1: t = mk(0, 2, 3, 'h41);
                5'd2: t = mk(0, 3, 4, 'h42);
                5'd3: t = mk(0, 4, 1, 'h43);
                5'd4: t = mk(1, 3, 2, 'h44);
                5'd5: t = mk(1, 4, 3, 'h45);
                default: t = '0;
            endcase
            2'd2: case (i)
                5'd0: t = mk(5, 6, 7, 'h80);
                5'd1: t = mk(8, 20, 9, 'h81);
                5'd2: t = mk(10, 11, 12, 'h82);
                default: t = '0;
            endcase
            default: t = mk(k % 18, (k + 1) % 18, (k + 2) % 18, 'hc0 + k);
        endcase
        return t;
    endfunction

    function automatic vertex_3d_t vert_of(input logic [4:0] idx);
        vertex_3d_t v;
        int k;
        k = int'(idx);
        v.x = 10'(k * 5 - 40);
        v.y = 10'(k * 2);
        v.z = 10'(-k * 7);
        if (k >= NUM_VERT) v = '0;
        return v;
    endfunction

    function automatic logic [PW-1:0] exp_pkt(input logic [1:0] m, input int i, input logic last);
        triangle_t t;
        t = tri_of(m, 5'(i));
        return {vert_of(t.v0), vert_of(t.v1), vert_of(t.v2), t.color, last};
    endfunction

    assign tri_in        = tri_of(model_select, tri_idx);
    assign vert_in       = vert_of(vert_idx);
    assign num_triangles = scene_n;

    // scoreboard capture
    logic [PW-1:0] obs_pkt;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] obs_q[$];
    int            obs_cyc_q[$];
    int            done_cyc_q[$];
    int            ov_cnt = 0;
    int            bad_cnt = 0;
    int            stall_cycles = 0;
    int            stall_changes = 0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_pkt = '0;

    assign obs_pkt = {pkt_if.out_v0, pkt_if.out_v1, pkt_if.out_v2, pkt_if.out_color, pkt_if.out_last};

    always @(negedge clk) begin
        if (frame_done) done_cyc_q.push_back(cyc);
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (bad_index) bad_cnt <= bad_cnt + 1;
        if (pkt_if.out_valid) begin
            if (prev_stall && obs_pkt !== prev_pkt) stall_changes <= stall_changes + 1;
            if (!pkt_if.out_ready) begin
                stall_cycles <= stall_cycles + 1;
                prev_stall   <= 1'b1;
                prev_pkt     <= obs_pkt;
            end else begin
                prev_stall <= 1'b0;
                obs_q.push_back(obs_pkt);
                obs_cyc_q.push_back(cyc);
            end
        end else begin
            if (prev_stall && rst_n) stall_changes <= stall_changes + 1;
            prev_stall <= 1'b0;
        end
    end

    // driver tasks
    task automatic start_frame(input logic [1:0] m, input int cx, input int cz,
                               input logic [4:0] n, output int t);
        @(posedge clk); #1;
        scene_n         = n;
        model_select_in = m;
        cam_x_in        = 10'(cx);
        cam_z_in        = 10'(cz);
        frame_start     = 1'b1;
        t               = cyc;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cyc_q.size() > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        pkt_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({pkt_if.out_valid, busy, model_select, cam_x, cam_z, obs_pkt} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b busy=%b model=%0d cam=%0d/%0d pkt=%h want all zero",
                     pkt_if.out_valid, busy, model_select, cam_x, cam_z, obs_pkt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (state_dbg !== SEQ_IDLE || tri_idx !== 5'd0 || vert_idx !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_idle: got state=%0d tri_idx=%0d vert_idx=%0d want 0 0 0",
                     state_dbg, tri_idx, vert_idx);
        end
        tests_run++;
        if ({frame_done, overrun, bad_index} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b want 000", {frame_done, overrun, bad_index});
        end
    endtask

    task automatic test_backpressure();
        int  t, b_o, b_d, sc0, ch0;
        bit  stalled;
        b_o = obs_q.size(); b_d = done_cyc_q.size();
        sc0 = stall_cycles; ch0 = stall_changes;
        stalled = 1'b0;
        pkt_if.out_ready = 1'b1;
        start_frame(2'd1, -20, 45, 5'd6, t);
        for (int i = 0; i < 300 && done_cyc_q.size() == b_d; i++) begin
            @(posedge clk); #1;
            if (!stalled && pkt_if.out_valid && obs_q.size() == b_o + 1) begin
                pkt_if.out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                pkt_if.out_ready = 1'b1;
                stalled = 1'b1;
            end
        end
        tests_run++;
        if (obs_q.size() - b_o != 6) begin
            tests_failed++;
            $display("FAIL pyr_count: got %0d packets want 6", obs_q.size() - b_o);
        end
        tests_run++;
        if (stall_cycles - sc0 != 3 || stall_changes - ch0 != 0) begin
            tests_failed++;
            $display("FAIL pyr_stall: got stall_cycles=%0d changes=%0d want 3 0",
                     stall_cycles - sc0, stall_changes - ch0);
        end
        for (int i = 0; i < 6 && b_o + i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[b_o + i] !== exp_pkt(2'd1, i, i == 5) ||
                obs_cyc_q[b_o + i] != t + ((i == 0) ? 5 : 8 + 5 * i)) begin
                tests_failed++;
                $display("FAIL pyr_pkt[%0d]: got %h @%0d want %h @%0d", i, obs_q[b_o + i],
                         obs_cyc_q[b_o + i] - t, exp_pkt(2'd1, i, i == 5), (i == 0) ? 5 : 8 + 5 * i);
            end
        end
        tests_run++;
        if (done_cyc_q.size() == b_d || done_cyc_q[done_cyc_q.size() - 1] != t + 34) begin
            tests_failed++;
            $display("FAIL pyr_done: got done entries=%0d want frame_done at T+34", done_cyc_q.size() - b_d);
        end
    endtask

    task automatic test_cube();
        int t, b_o, b_d;
        bit ok;
        b_o = obs_q.size(); b_d = done_cyc_q.size();
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(exp_pkt(2'd0, i, i == 11));
        pkt_if.out_ready = 1'b1;
        start_frame(2'd0, 13, -7, 5'd12, t);
        tests_run++;
        if (model_select !== 2'd0 || cam_x !== 10'sd13 || cam_z !== -10'sd7) begin
            tests_failed++;
            $display("FAIL cube_cfg: got model=%0d cam=%0d/%0d want 0 13/-7", model_select, cam_x, cam_z);
        end
        wait_done(b_d, 200, ok);
        tests_run++;
        if (!ok || done_cyc_q[done_cyc_q.size() - 1] != t + 61) begin
            tests_failed++;
            $display("FAIL cube_done: got seen=%0d want frame_done at T+61", ok);
        end
        tests_run++;
        if (obs_q.size() - b_o != 12) begin
            tests_failed++;
            $display("FAIL cube_count: got %0d want 12", obs_q.size() - b_o);
        end
        for (int i = 0; i < 12 && b_o + i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[b_o + i] !== exp_q[i] || obs_cyc_q[b_o + i] != t + 5 + 5 * i) begin
                tests_failed++;
                $display("FAIL cube_pkt[%0d]: got %h @T+%0d want %h @T+%0d", i, obs_q[b_o + i],
                         obs_cyc_q[b_o + i] - t, exp_q[i], 5 + 5 * i);
            end
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || state_dbg !== SEQ_IDLE) begin
            tests_failed++;
            $display("FAIL cube_idle: got busy=%b state=%0d want 0 0", busy, state_dbg);
        end
    endtask

    task automatic test_zero_and_clamp();
        int t, b_o, b_d;
        bit ok;
        b_o = obs_q.size(); b_d = done_cyc_q.size();
        pkt_if.out_ready = 1'b1;
        start_frame(2'd1, 0, 0, 5'd0, t);
        wait_done(b_d, 20, ok);
        tests_run++;
        if (!ok || done_cyc_q[done_cyc_q.size() - 1] != t + 2 || obs_q.size() != b_o) begin
            tests_failed++;
            $display("FAIL zero_tri: got seen=%0d packets=%0d want done at T+2 and 0 packets",
                     ok, obs_q.size() - b_o);
        end
        b_o = obs_q.size(); b_d = done_cyc_q.size();
        start_frame(2'd3, 1, 2, 5'd31, t);
        wait_done(b_d, 400, ok);
        tests_run++;
        if (!ok || obs_q.size() - b_o != 24 || done_cyc_q[done_cyc_q.size() - 1] != t + 121) begin
            tests_failed++;
            $display("FAIL clamp_count: got seen=%0d packets=%0d want 24 packets, done at T+121",
                     ok, obs_q.size() - b_o);
        end
        for (int i = 0; i < 24 && b_o + i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[b_o + i] !== exp_pkt(2'd3, i, i == 23)) begin
                tests_failed++;
                $display("FAIL clamp_pkt[%0d]: got %h want %h", i, obs_q[b_o + i], exp_pkt(2'd3, i, i == 23));
            end
        end
    endtask

    task automatic test_overrun();
        int t, b_o, b_d, ov0;
        bit ok;
        b_o = obs_q.size(); b_d = done_cyc_q.size(); ov0 = ov_cnt;
        pkt_if.out_ready = 1'b1;
        start_frame(2'd0, 50, -60, 5'd12, t);
        repeat (20) @(posedge clk);
        #1;
        model_select_in = 2'd2;
        cam_x_in        = 10'sd100;
        cam_z_in        = 10'sd100;
        frame_start     = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        tests_run++;
        if (ov_cnt - ov0 != 1 || model_select !== 2'd0 || cam_x !== 10'sd50 || cam_z !== -10'sd60) begin
            tests_failed++;
            $display("FAIL overrun_cfg: got pulses=%0d model=%0d cam=%0d/%0d want 1 0 50/-60",
                     ov_cnt - ov0, model_select, cam_x, cam_z);
        end
        wait_done(b_d, 200, ok);
        tests_run++;
        if (!ok || obs_q.size() - b_o != 12 || done_cyc_q[done_cyc_q.size() - 1] != t + 61) begin
            tests_failed++;
            $display("FAIL overrun_frame: got seen=%0d packets=%0d want 12 packets, done at T+61",
                     ok, obs_q.size() - b_o);
        end
        for (int i = 0; i < 12 && b_o + i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[b_o + i] !== exp_pkt(2'd0, i, i == 11)) begin
                tests_failed++;
                $display("FAIL overrun_pkt[%0d]: got %h want %h", i, obs_q[b_o + i], exp_pkt(2'd0, i, i == 11));
            end
        end
    endtask

    task automatic test_bad_index();
        int t, b_o, b_d, bad0;
        bit ok;
        b_o = obs_q.size(); b_d = done_cyc_q.size(); bad0 = bad_cnt;
        pkt_if.out_ready = 1'b1;
        start_frame(2'd2, 0, 0, 5'd3, t);
        wait_done(b_d, 100, ok);
        tests_run++;
        if (!ok || bad_cnt - bad0 != 1 || obs_q.size() - b_o != 2) begin
            tests_failed++;
            $display("FAIL bad_mid: got seen=%0d bad=%0d packets=%0d want 1 1 2",
                     ok, bad_cnt - bad0, obs_q.size() - b_o);
        end else begin
            tests_run++;
            if (obs_q[b_o] !== exp_pkt(2'd2, 0, 1'b0) || obs_q[b_o + 1] !== exp_pkt(2'd2, 2, 1'b1)) begin
                tests_failed++;
                $display("FAIL bad_mid_pkts: got %h %h want %h %h", obs_q[b_o], obs_q[b_o + 1],
                         exp_pkt(2'd2, 0, 1'b0), exp_pkt(2'd2, 2, 1'b1));
            end
        end
        b_o = obs_q.size(); b_d = done_cyc_q.size(); bad0 = bad_cnt;
        start_frame(2'd2, 0, 0, 5'd2, t);
        wait_done(b_d, 100, ok);
        tests_run++;
        if (!ok || bad_cnt - bad0 != 1 || obs_q.size() - b_o != 1) begin
            tests_failed++;
            $display("FAIL bad_last: got seen=%0d bad=%0d packets=%0d want 1 1 1",
                     ok, bad_cnt - bad0, obs_q.size() - b_o);
        end else begin
            tests_run++;
            if (obs_q[b_o] !== exp_pkt(2'd2, 0, 1'b0)) begin
                tests_failed++;
                $display("FAIL bad_last_pkt: got %h want %h", obs_q[b_o], exp_pkt(2'd2, 0, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, b_o, b_d;
        bit ok;
        pkt_if.out_ready = 1'b0;
        start_frame(2'd0, 33, 44, 5'd12, t);
        for (int i = 0; i < 20 && !pkt_if.out_valid; i++) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (pkt_if.out_valid !== 1'b1 || state_dbg !== SEQ_EMIT) begin
            tests_failed++;
            $display("FAIL rstmid_emit: got valid=%b state=%0d want 1 %0d", pkt_if.out_valid, state_dbg, SEQ_EMIT);
        end
        b_d = done_cyc_q.size();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pkt_if.out_valid !== 1'b0 || busy !== 1'b0 || cam_x !== 10'sd0 || cam_z !== 10'sd0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got valid=%b busy=%b cam=%0d/%0d want 0 0 0/0",
                     pkt_if.out_valid, busy, cam_x, cam_z);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pkt_if.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (done_cyc_q.size() != b_d) begin
            tests_failed++;
            $display("FAIL rstmid_nodone: got %0d frame_done pulses want 0", done_cyc_q.size() - b_d);
        end
        b_o = obs_q.size(); b_d = done_cyc_q.size();
        start_frame(2'd0, 33, 44, 5'd12, t);
        wait_done(b_d, 200, ok);
        tests_run++;
        if (!ok || obs_q.size() - b_o != 12) begin
            tests_failed++;
            $display("FAIL rstmid_count: got seen=%0d packets=%0d want 12", ok, obs_q.size() - b_o);
        end else begin
            tests_run++;
            if (obs_q[b_o] !== exp_pkt(2'd0, 0, 1'b0) || obs_cyc_q[b_o] != t + 5) begin
                tests_failed++;
                $display("FAIL rstmid_first: got %h @T+%0d want %h @T+5", obs_q[b_o],
                         obs_cyc_q[b_o] - t, exp_pkt(2'd0, 0, 1'b0));
            end
        end
    endtask

    // sequence and report
    initial begin
        test_reset();
        test_backpressure();
        test_cube();
        test_zero_and_clamp();
        test_overrun();
        test_bad_index();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/triangle_sequencer.md
TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

Interface
REQ-001 SHALL have parameter MAX_TRI, default 24, maximum triangle slots per model.
REQ-002 SHALL have parameter NUM_VERT, default 18, vertex table depth.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port frame_start  in  1  one-cycle pulse requesting a frame pass.
REQ-006 SHALL have port model_select_in  in  2  requested model.
REQ-007 SHALL have port cam_x_in / cam_z_in  in  10 signed each  requested camera position.
REQ-008 SHALL have port model_select  out  2  frame-latched model, drives scene table.
REQ-009 SHALL have port cam_x / cam_z  out  10 signed each  frame-latched camera.
REQ-010 SHALL have port num_triangles  in  5  triangle count from scene table.
REQ-011 SHALL have port tri_idx  out  5  triangle table read index.
REQ-012 SHALL have port tri_in  in  triangle_t  triangle at tri_idx, combinational.
REQ-013 SHALL have port vert_idx  out  5  vertex table read index.
REQ-014 SHALL have port vert_in  in  vertex_3d_t  vertex at vert_idx, combinational.
REQ-015 SHALL have port out_valid / out_ready  out / in  1 each  triangle packet handshake.
REQ-016 SHALL have port out_v0, out_v1, out_v2  out  vertex_3d_t each  assembled vertices.
REQ-017 SHALL have port out_color  out  color type of triangle_t  face colour.
REQ-018 SHALL have port out_last  out  1  high with last packet of frame.
REQ-019 SHALL have port busy  out  1  high in every state except IDLE.
REQ-020 SHALL have port frame_done / overrun / bad_index  out  1 each  one-cycle status pulses.

Function
REQ-021 SHALL implement FSM: IDLE, FETCH_TRI, FETCH_V0, FETCH_V1, FETCH_V2, EMIT, DONE.
REQ-022 IDLE + frame_start: latch model_select, cam_x, cam_z; tri counter=0; go FETCH_TRI next cycle.
REQ-023 model_select, cam_x, cam_z SHALL change only on accepted frame_start (frame-coherent config).
REQ-024 Effective count N = min(num_triangles, MAX_TRI), sampled in first FETCH_TRI of the frame.
REQ-025 N=0: FETCH_TRI -> DONE, no packet issued.
REQ-026 FETCH_TRI: tri_idx=counter; register tri_in.
REQ-027 FETCH_Vk: vert_idx = registered vk; register vert_in into out_vk; one cycle each.
REQ-028 Any vk >= NUM_VERT: pulse bad_index, skip triangle (no packet), continue with next.
REQ-029 EMIT: out_valid=1; out_v0..2, out_color, out_last held stable until out_ready.
REQ-030 out_last=1 iff counter == N-1.
REQ-031 Handshake out_valid&&out_ready: counter+1; next FETCH_TRI, or DONE if last.
REQ-032 Latency: frame_start at cycle T -> out_valid first high at T+5 (ready held high); 5 cycles/triangle.
REQ-033 DONE: frame_done pulse for one cycle, then IDLE.
REQ-034 frame_start outside IDLE: ignored, overrun pulsed same cycle; latched config unchanged.
REQ-035 tri_idx and vert_idx SHALL be 0 when not in the fetch state that uses them.
REQ-036 Skipped last triangle (REQ-028) SHALL still end frame via DONE; out_last not asserted.

Reset
REQ-037 rst_n low at any time: state IDLE, all outputs 0 (model_select=0, cam 0, out_* 0), counter 0, immediately and asynchronously.
REQ-038 Reset mid-frame SHALL discard in-flight packet; no frame_done issued.

Structure
REQ-039 triangle_t, vertex_3d_t, colour type, MAX_TRI, NUM_VERT and seq_state_t enum SHALL live in graphics_type.sv.
REQ-040 Single module, no sub-module; FSM plus datapath registers only.

Verification
REQ-041 Cube (model 0, N=12), out_ready=1: 12 packets, first at T+5, spacing 5, out_last on 12th, frame_done at T+61.
REQ-042 Pyramid with out_ready low 3 cycles on packet 2: outputs stable throughout, 6 packets total, order unchanged.
REQ-043 num_triangles=0: no out_valid, frame_done at T+2; num_triangles=31: exactly 24 packets.
REQ-044 frame_start and model_select_in=2 mid-frame of cube: overrun pulse, model_select stays 0, 12 cube packets.
REQ-045 Triangle with v1=20: bad_index pulse, packet skipped, remaining packets intact.
REQ-046 rst_n low during EMIT: out_valid 0 same cycle, busy 0, new frame_start restarts at triangle 0.
